// File: rtl/result_argmax_collector.sv
// Collects NUM_CLASSES fp32 results, buffers them and reports the argmax.
// Optional ReLU on inputs: define RESULT_ARGMAX_RELU_EN.
module result_argmax_collector #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_BITS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [31:0]         in_data,
  output logic                in_ready,
  output logic                class_valid,
  output logic [IDX_BITS-1:0] class_index,
  output logic [31:0]         max_value,
  output logic                busy,
  output logic [IDX_BITS-1:0] count,
  output logic                overflow,
  input  logic [IDX_BITS-1:0] rd_addr,
  output logic [31:0]         rd_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(NUM_CLASSES - 1);
  localparam logic [IDX_BITS:0]   NC   = (IDX_BITS + 1)'(NUM_CLASSES);

  logic [1:0]          state_q, state_d;
  logic [IDX_BITS-1:0] count_q, count_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [31:0]         max_q, max_d;
  logic                cv_q, cv_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         rd_q, rd_d;
  logic [31:0]         buf_q [NUM_CLASSES];

  logic [31:0] sv;
  logic        hs, cand_nan, max_nan, wins;

  // Ordered key: monotonic unsigned mapping of fp32, with -0 folded onto +0
  function automatic logic [31:0] okey(input logic [31:0] v);
    if (v[30:0] == 31'd0) return 32'h8000_0000;
    return v[31] ? ~v : {1'b1, v[30:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

`ifdef RESULT_ARGMAX_RELU_EN
  assign sv = in_data[31] ? 32'h0 : in_data;
`else
  assign sv = in_data;
`endif

  assign in_ready = (state_q == COLLECT) && !start;
  assign hs       = in_valid && in_ready;
  assign cand_nan = is_nan(sv);
  assign max_nan  = is_nan(max_q);
  assign wins     = (count_q == '0) ||
                    (!cand_nan && (max_nan || okey(sv) > okey(max_q)));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    max_d   = max_q;
    cv_d    = 1'b0;
    ovf_d   = ovf_q;
    rd_d    = ({1'b0, rd_addr} < NC) ? buf_q[rd_addr] : 32'h0;
    if (start) begin
      state_d = COLLECT;
      count_d = '0;
      idx_d   = '0;
      max_d   = 32'h0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (hs) begin
            count_d = count_q + 1'b1;
            if (wins) begin
              idx_d = count_q;
              max_d = sv;
            end
            if (count_q == LAST) begin
              state_d = DONE;
              cv_d    = 1'b1;
            end
          end
        end
        DONE:    if (in_valid) ovf_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      max_q   <= 32'h0;
      cv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      cv_q    <= cv_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

  // Buffer contents survive reset; only the write is gated
  always_ff @(posedge clk) begin
    if (hs && !reset) buf_q[count_q] <= sv;
  end

  assign class_valid = cv_q;
  assign class_index = idx_q;
  assign max_value   = max_q;
  assign busy        = (state_q == COLLECT);
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign rd_data     = rd_q;

endmodule

// File: doc/result_argmax_collector.md
RESULT_ARGMAX_COLLECTOR -- requirements
Module: result_argmax_collector

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: number of MAC results per image (2..16).
REQ-002 SHALL have parameter IDX_BITS, default 4: width of the class index and the buffer address.
REQ-003 SHALL have port clk  input  1: the single clock; one clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1: reset is synchronous and active-high.
REQ-005 SHALL have port start  input  1: one-cycle pulse that begins a new image.
REQ-006 SHALL have port in_valid  input  1: the fp_mac result on in_data is valid.
REQ-007 SHALL have port in_data  input  32: IEEE-754 fp32 neuron result.
REQ-008 SHALL have port in_ready  output  1: the block accepts in_data this cycle.
REQ-009 SHALL have port class_valid  output  1: one-cycle pulse when the argmax is final.
REQ-010 SHALL have port class_index  output  IDX_BITS: index of the winning neuron.
REQ-011 SHALL have port max_value  output  32: fp32 value of the winner (post-ReLU when enabled).
REQ-012 SHALL have port busy  output  1: high while in COLLECT.
REQ-013 SHALL have port count  output  IDX_BITS: number of results accepted in the current image.
REQ-014 SHALL have port overflow  output  1: sticky; a result arrived while in DONE.
REQ-015 SHALL have port rd_addr  input  IDX_BITS: readback address into the result buffer.
REQ-016 SHALL have port rd_data  output  32: buffer[rd_addr], registered.

Function
REQ-017 SHALL implement FSM IDLE -> COLLECT on start; COLLECT -> DONE on accepting result NUM_CLASSES-1; DONE -> COLLECT on start.
REQ-018 SHALL treat start in any state as restart: count=0, overflow=0, running max cleared, state=COLLECT.
REQ-019 SHALL drive in_ready = (state==COLLECT) && !start; a handshake is in_valid && in_ready.
REQ-020 SHALL, on each handshake, write the value into buffer[count], increment count, and update the running max/index.
REQ-021 SHALL compare by ordered key: sign 0 -> {1,bits[30:0]}, sign 1 -> ~bits; unsigned compare; -0 and +0 are equal.
REQ-022 SHALL treat NaN (exp=8'hFF, mantissa!=0) as losing to everything; if all are NaN, the winner is index 0.
REQ-023 SHALL require strictly greater to replace the max, so on ties the lowest index wins.
REQ-024 SHALL treat the first accepted result of an image as the initial max unconditionally.
REQ-025 SHALL pulse class_valid exactly one cycle after the final handshake.
REQ-026 SHALL hold class_index and max_value stable from that pulse until the next start.
REQ-027 SHALL set overflow when in_valid is high in DONE; the data is dropped and class outputs are unchanged.
REQ-028 SHALL ignore in_valid in IDLE without setting overflow.
REQ-029 SHALL give rd_data one-cycle latency; a same-cycle write to rd_addr returns the old value.
REQ-030 SHALL make rd_data 0 for rd_addr >= NUM_CLASSES.

Reset
REQ-031 SHALL, on reset, set state=IDLE, in_ready=0, busy=0, count=0, class_valid=0, class_index=0, max_value=0, overflow=0, rd_data=0.
REQ-032 SHALL make reset dominate start; reset mid-COLLECT discards the partial image with no class_valid.
REQ-033 SHALL not clear buffer contents on reset.

Configuration
REQ-034 SHALL, with RESULT_ARGMAX_RELU_EN defined, replace any input with sign bit 1 (including -0 and negative NaN) by 32'h00000000 before storing and comparing.
REQ-035 SHALL, without RESULT_ARGMAX_RELU_EN, store and compare raw values; all other behaviour is identical.

Verification
REQ-036 SHALL cover: start, then 10 results 1.0..10.0 (3F800000..41200000) back-to-back -> class_valid one cycle after the 10th, index 9, max_value 41200000.
REQ-037 SHALL cover: results with 40400000 (3.0) at indices 2 and 7, all others smaller -> index 2 (tie goes to the lowest).
REQ-038 SHALL cover: all results negative, -5.0 at index 4 and the rest below it, macro off -> index 4, max_value C0A00000; macro on -> index 0, max_value 00000000.
REQ-039 SHALL cover: index 3 is 7FC00000 (NaN), the rest are 1.0 -> index 0; and in_valid in DONE -> overflow=1, outputs unchanged.
REQ-040 SHALL cover: start together with in_valid -> in_ready=0, count=0; reset after 5 results -> no class_valid, all outputs at reset values.
REQ-041 SHALL cover: after an image completes, rd_addr 0..9 -> rd_data equals the accepted values one cycle later; rd_addr 12 -> 0.
